// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, strobe encodings and decode helpers for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    localparam logic [1:0] c_WR_SW = 2'b00;
    localparam logic [1:0] c_WR_SH = 2'b01;
    localparam logic [1:0] c_WR_SB = 2'b10;

    localparam logic [2:0] c_RD_LB  = 3'b000;
    localparam logic [2:0] c_RD_LH  = 3'b001;
    localparam logic [2:0] c_RD_LBU = 3'b010;
    localparam logic [2:0] c_RD_LHU = 3'b011;
    localparam logic [2:0] c_RD_LW  = 3'b100;

    // Size code 11 falls through to the word encodings.
    function automatic logic [1:0] wr_strb_f(input logic [1:0] size);
        case (size)
            c_SZ_BYTE: wr_strb_f = c_WR_SB;
            c_SZ_HALF: wr_strb_f = c_WR_SH;
            default:   wr_strb_f = c_WR_SW;
        endcase
    endfunction

    function automatic logic [2:0] rd_strb_f(input logic [1:0] size, input logic uns);
        case (size)
            c_SZ_BYTE: rd_strb_f = uns ? c_RD_LBU : c_RD_LB;
            c_SZ_HALF: rd_strb_f = uns ? c_RD_LHU : c_RD_LH;
            default:   rd_strb_f = c_RD_LW;
        endcase
    endfunction

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            c_SZ_BYTE: misaligned_f = 1'b0;
            c_SZ_HALF: misaligned_f = addr_lo[0];
            default:   misaligned_f = |addr_lo;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_arb
// Description : Two-way round-robin arbiter with one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic r_last;

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        if (req[0] && (!req[1] || r_last)) begin
            gnt     = 2'b01;
            gnt_idx = 1'b0;
        end else if (req[1]) begin
            gnt     = 2'b10;
            gnt_idx = 1'b1;
        end
    end

    // Starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (take && |req) begin
            r_last <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates LSU and debug/DMA requesters onto a single-port
//               data memory with a three-state access sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][1:0]        req_size,
    input  logic [1:0]             req_unsigned,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_we0,
    output logic [1:0]             mem_wr_strb,
    output logic [2:0]             mem_rd_strb,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic                r_idx;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [1:0]          w_gnt;
    logic                w_gnt_idx;
    logic                w_idle;
    logic                w_mis;

    assign w_idle = (r_state == ST_IDLE);
    assign w_mis  = misaligned_f(r_size, r_addr[1:0]);

    dmem_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .take    (w_idle),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_comb begin
        w_next      = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        mem_we0     = 1'b0;
        mem_wr_strb = c_WR_SW;
        mem_rd_strb = c_RD_LW;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_gnt;
                if (|req_valid) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we0     = r_we & ~w_mis;
                mem_wr_strb = wr_strb_f(r_size);
                mem_rd_strb = rd_strb_f(r_size, r_uns);
                w_next      = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = r_idx ? 2'b10 : 2'b01;
                if (rsp_ready[r_idx]) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_idle && |req_valid) begin
                r_idx   <= w_gnt_idx;
                r_we    <= req_we[w_gnt_idx];
                r_size  <= req_size[w_gnt_idx];
                r_uns   <= req_unsigned[w_gnt_idx];
                r_addr  <= req_addr[w_gnt_idx];
                r_wdata <= req_wdata[w_gnt_idx];
            end
            // Stores and faulting accesses report zero data.
            if (r_state == ST_ACCESS) begin
                r_rdata <= (r_we || w_mis) ? '0 : mem_rdata;
                r_err   <= w_mis;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, byte-address width; DATA_W, default 32, data width.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  req_valid  in  2  per-requester request valid; index 0 = LSU, index 1 = debug/DMA
  req_ready  out  2  per-requester request accept
  req_we  in  2  1 = store, 0 = load
  req_size  in  2x2  00 byte, 01 half, 10 word; 11 is treated as word
  req_unsigned  in  2  zero-extend load when set
  req_addr  in  2xADDR_W  byte address
  req_wdata  in  2xDATA_W  store data, LSB-aligned
  rsp_valid  out  2  response valid
  rsp_ready  in  2  response accept
  rsp_rdata  out  DATA_W  load data, shared by both requesters
  rsp_err  out  1  misaligned-access flag
  mem_we0  out  1  memory write enable
  mem_wr_strb  out  2  SW 00, SH 01, SB 10
  mem_rd_strb  out  3  LB 000, LH 001, LBU 010, LHU 011, LW 100
  mem_addr  out  ADDR_W  drives both memory read and write address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  combinational read data from the memory

Function
REQ-003 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-004 IDLE: if any req_valid is set, SHALL grant one requester, assert req_ready for that requester only, combinationally in the same cycle, capture its we/size/unsigned/addr/wdata, and go to ACCESS.
REQ-005 Arbitration SHALL be round-robin: with both requesters valid, the requester not served last wins; the post-reset last-served value is 1, so requester 0 wins the first tie.
REQ-006 ACCESS SHALL last exactly 1 cycle and drive mem_addr, mem_wdata, mem_wr_strb and mem_rd_strb from the captured request.
REQ-007 In ACCESS, mem_we0 SHALL equal captured we AND NOT misaligned.
REQ-008 In ACCESS, mem_rdata SHALL be registered into rsp_rdata for loads; for stores rsp_rdata SHALL be written to 0.
REQ-009 Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=00.
REQ-010 A misaligned access SHALL produce no write, set rsp_err=1 and return rsp_rdata=0.
REQ-011 RESP SHALL hold rsp_valid for the granted requester, with rsp_rdata and rsp_err stable, until rsp_ready; on rsp_ready it SHALL return to IDLE.
REQ-012 req_ready SHALL be 0 outside IDLE.
REQ-013 A new grant SHALL NOT occur in the same cycle as the response handshake, giving a minimum of 3 cycles per transaction.
REQ-014 The size/unsigned encoding SHALL map as: byte signed -> LB, byte unsigned -> LBU, half signed -> LH, half unsigned -> LHU, word -> LW; store sizes byte/half/word -> SB/SH/SW.
REQ-015 Outside ACCESS: mem_we0=0, mem_wr_strb=SW, mem_rd_strb=LW, mem_addr and mem_wdata hold their last captured value.
REQ-016 A requester SHALL hold its request fields stable while req_valid=1 and req_ready=0; a requester that drops req_valid before grant SHALL NOT be served.

Reset
REQ-017 On rst low, the FSM SHALL go to IDLE asynchronously and clear all outputs and capture registers to 0, with mem_wr_strb=SW and mem_rd_strb=LW.
REQ-018 Reset during ACCESS or RESP SHALL abort the transaction: no write, no response.
REQ-019 After reset release, the first grant SHALL occur on the first rising edge with a valid request.

Structure
REQ-020 A shared package dmem_pkg SHALL hold the FSM state enum, the SW/SH/SB and LB..LW encodings, and the size codes.
REQ-021 Arbitration SHALL be a sub-module dmem_rr_arb (2-way round-robin, last-served register, one-hot grant).

Verification
REQ-022 Requester 0 stores a word 0xDEADBEEF at addr 0x10, then loads LW from 0x10 -> one mem_we0 pulse with mem_addr=0x10; load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-023 Both requesters valid every cycle, back to back -> grants alternate 0,1,0,1 starting with 0; each transaction takes 3 cycles with rsp_ready tied high.
REQ-024 Requester 1 does a half load from 0x13 -> mem_we0 stays 0, rsp_err=1, rsp_rdata=0; a half store to 0x13 -> no write.
REQ-025 Memory word 0x000000F0, LB and LBU from addr 0x0 -> mem_rd_strb=000 then 010; rsp_rdata returns the mem_rdata value presented.
REQ-026 rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0 for the other requester; on release the next grant follows one cycle later.
REQ-027 rst asserted during ACCESS of a store -> no mem_we0 pulse, no rsp_valid; state is IDLE after release.
